// File: rtl/aes_tcdm_mux.sv
`default_nettype none
// ============================================================================
// Module   : aes_tcdm_mux
// Purpose  : Round-robin N:1 HWPE-Mem request multiplexer with an in-order
//            ID FIFO that routes each memory response back to its issuer.
// Revision : 1.0 - initial release
// ============================================================================
module aes_tcdm_mux #(
  parameter int MP    = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [MP-1:0]            in_req,
  output logic [MP-1:0]            in_gnt,
  input  logic [MP*32-1:0]         in_add,
  input  logic [MP-1:0]            in_wen,
  input  logic [MP*4-1:0]          in_be,
  input  logic [MP*32-1:0]         in_data,
  output logic [MP*32-1:0]         in_r_data,
  output logic [MP-1:0]            in_r_valid,
  output logic                     out_req,
  output logic [31:0]              out_add,
  output logic                     out_wen,
  output logic [3:0]               out_be,
  output logic [31:0]              out_data,
  input  logic                     out_gnt,
  input  logic [31:0]              out_r_data,
  input  logic                     out_r_valid,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                     err_o
);

  localparam int c_pw = (MP > 1) ? $clog2(MP) : 1;
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH+1);

  logic [c_pw-1:0] r_ptr;
  logic [c_pw-1:0] r_fifo [DEPTH];
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_cw-1:0] r_count;
  logic            r_err;

  logic [c_pw-1:0] w_sel;
  logic            w_any;
  logic [c_cw-1:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_hs;
  logic            w_pop;
  logic [c_pw-1:0] w_head;

  // While reset is held the block behaves as if nothing is outstanding.
  assign w_count = rst_i ? '0 : r_count;
  assign w_full  = (w_count == c_cw'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_head  = r_fifo[r_rptr];

  // Round-robin pick: first requester at or after the priority pointer.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 0; i < MP; i++) begin
      if (!w_any && in_req[(int'(r_ptr) + i) % MP]) begin
        w_any = 1'b1;
        w_sel = c_pw'((int'(r_ptr) + i) % MP);
      end
    end
  end

  assign out_req  = w_any & ~w_full;
  assign out_add  = in_add[int'(w_sel)*32 +: 32];
  assign out_wen  = in_wen[w_sel];
  assign out_be   = in_be[int'(w_sel)*4 +: 4];
  assign out_data = in_data[int'(w_sel)*32 +: 32];
  assign w_hs     = out_req & out_gnt;
  assign w_pop    = out_r_valid & ~w_empty;

  // Grant goes only to the selected port; responses go only to the FIFO head.
  always_comb begin
    in_gnt     = '0;
    in_r_valid = '0;
    in_r_data  = '0;
    if (w_hs) begin
      in_gnt[w_sel] = 1'b1;
    end
    if (w_pop) begin
      in_r_valid[w_head]                 = 1'b1;
      in_r_data[int'(w_head)*32 +: 32]   = out_r_data;
    end
  end

  // ID storage carries no reset: validity is tracked by the pointers/count.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_fifo[r_wptr] <= w_sel;
    end
  end

  // Pointer, occupancy and sticky-error bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_wptr <= r_wptr + 1'b1;
        r_ptr  <= c_pw'((int'(w_sel) + 1) % MP);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (out_r_valid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_tcdm_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_tcdm_mux
// Purpose  : Directed bench with a queue-based reference model for
//            aes_tcdm_mux (MP=2, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_tcdm_mux;

  localparam int MP    = 2;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [1:0]    in_req;
  logic [1:0]    in_gnt;
  logic [63:0]   in_add;
  logic [1:0]    in_wen;
  logic [7:0]    in_be;
  logic [63:0]   in_data;
  logic [63:0]   in_r_data;
  logic [1:0]    in_r_valid;
  logic          out_req;
  logic [31:0]   out_add;
  logic          out_wen;
  logic [3:0]    out_be;
  logic [31:0]   out_data;
  logic          out_gnt;
  logic [31:0]   out_r_data;
  logic          out_r_valid;
  logic [2:0]    outstanding_o;
  logic          err_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int q[$];
  int mptr = 0;
  bit merr = 1'b0;

  always #5 clk_i = ~clk_i;

  aes_tcdm_mux #(.MP(MP), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
    .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
    .out_req(out_req), .out_add(out_add), .out_wen(out_wen), .out_be(out_be),
    .out_data(out_data), .out_gnt(out_gnt), .out_r_data(out_r_data),
    .out_r_valid(out_r_valid), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin winner from the rule: first requester counting up from ptr.
  function automatic int pick(input logic [1:0] req, input int ptr);
    for (int k = 0; k < MP; k++) begin
      if (req[(ptr + k) % MP]) return (ptr + k) % MP;
    end
    return -1;
  endfunction

  // Compare every cycle on the falling edge against the model.
  always @(negedge clk_i) begin
    int n, s;
    bit er;
    logic [1:0]  eg, ev;
    logic [63:0] ed;
    if (chk_en) begin
      n  = rst_i ? 0 : q.size();
      s  = pick(in_req, mptr);
      er = (s >= 0) && (n < DEPTH);
      eg = '0; ev = '0; ed = '0;
      if (er && out_gnt) eg[s] = 1'b1;
      if (out_r_valid && n > 0) begin
        ev[q[0]] = 1'b1;
        ed[q[0]*32 +: 32] = out_r_data;
      end
      chk("m_out_req", {63'd0, out_req}, {63'd0, er});
      if (er) begin
        chk("m_out_fields", {out_add, out_be, out_wen},
            {in_add[s*32 +: 32], in_be[s*4 +: 4], in_wen[s]});
        chk("m_out_data", {32'd0, out_data}, {32'd0, in_data[s*32 +: 32]});
      end
      chk("m_in_gnt", {62'd0, in_gnt}, {62'd0, eg});
      chk("m_in_r_valid", {62'd0, in_r_valid}, {62'd0, ev});
      chk("m_in_r_data", in_r_data, ed);
      chk("m_outstanding", {61'd0, outstanding_o}, 64'(q.size()));
      chk("m_err", {63'd0, err_o}, {63'd0, merr});
    end
  end

  // Advance the model on the rising edge.
  always @(posedge clk_i) begin
    int s;
    bit hs, pop;
    if (rst_i) begin
      q.delete();
      mptr = 0;
      merr = 1'b0;
    end else begin
      s   = pick(in_req, mptr);
      hs  = (s >= 0) && (q.size() < DEPTH) && out_gnt;
      pop = out_r_valid && (q.size() > 0);
      if (out_r_valid && q.size() == 0) merr = 1'b1;
      if (pop) void'(q.pop_front());
      if (hs) begin
        q.push_back(s);
        mptr = (s + 1) % MP;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b0; out_r_data = '0;
  endtask

  initial begin
    int gcount;
    rst_i = 1'b1;
    in_add = {32'h0000_2000, 32'h0000_1000};
    in_wen = 2'b11; in_be = 8'hFF; in_data = {32'h1111_1111, 32'h0000_0000};
    idle();
    step();
    chk_en = 1'b1;
    step();
    rst_i = 1'b0;
    #3;
    chk("reset_outstanding", {61'd0, outstanding_o}, 64'd0);
    chk("reset_err", {63'd0, err_o}, 64'd0);
    chk("reset_out_req", {63'd0, out_req}, 64'd0);
    step();

    // Alternating grants with responses one cycle later.
    in_req = 2'b11; out_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      out_r_valid = (k > 0);
      out_r_data  = 32'hD000_0000 + 32'(k);
      #3;
      chk("alt_gnt", {62'd0, in_gnt}, (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k > 0) chk("alt_rvalid", {62'd0, in_r_valid}, ((k - 1) % 2 == 0) ? 64'd1 : 64'd2);
      step();
    end
    in_req = 2'b00; out_r_valid = 1'b1; out_r_data = 32'hD000_0006;
    #3;
    chk("alt_last_rdata", in_r_data, {32'hD000_0006, 32'd0});
    step();
    idle();
    #3;
    chk("alt_drained", {61'd0, outstanding_o}, 64'd0);
    step();

    // Fill to DEPTH with responses withheld.
    in_req = 2'b01; out_gnt = 1'b1; gcount = 0;
    for (int k = 0; k < 6; k++) begin
      #3;
      gcount += int'(in_gnt[0]);
      step();
    end
    chk("full_grants", 64'(gcount), 64'd4);
    chk("full_count", {61'd0, outstanding_o}, 64'd4);
    chk("full_out_req", {63'd0, out_req}, 64'd0);
    out_r_valid = 1'b1; out_r_data = 32'hCAFE_0001;
    #3;
    chk("full_no_refill", {63'd0, out_req}, 64'd0);
    chk("full_pop_valid", {62'd0, in_r_valid}, 64'd1);
    step();
    out_r_valid = 1'b0;
    #3;
    chk("full_req_back", {63'd0, out_req}, 64'd1);
    step();
    in_req = 2'b00; out_r_valid = 1'b1;
    for (int k = 0; k < 4; k++) step();
    idle();
    #3;
    chk("full_drained", {61'd0, outstanding_o}, 64'd0);
    step();

    // Port 1 read then port 0 write, in-order responses.
    in_add = {32'h0000_0100, 32'h0000_0104};
    in_wen = 2'b10; in_data = {32'h0, 32'h1234_5678};
    in_req = 2'b10; out_gnt = 1'b1;
    step();
    in_req = 2'b01; out_r_valid = 1'b1; out_r_data = 32'hA5A5_A5A5;
    #3;
    chk("rw_wr_add", {32'd0, out_add}, 64'h104);
    chk("rw_wr_wen", {63'd0, out_wen}, 64'd0);
    chk("rw_rd_resp", {62'd0, in_r_valid}, 64'd2);
    chk("rw_rd_data", in_r_data, {32'hA5A5_A5A5, 32'd0});
    step();
    in_req = 2'b00; out_r_data = 32'h0;
    #3;
    chk("rw_wr_resp", {62'd0, in_r_valid}, 64'd1);
    step();
    idle();
    #3;
    chk("rw_drained", {61'd0, outstanding_o}, 64'd0);
    step();

    // Simultaneous push (port 0) and pop (port 1) at count 2.
    in_req = 2'b10; out_gnt = 1'b1;
    step();
    in_req = 2'b01;
    step();
    in_req = 2'b01; out_r_valid = 1'b1; out_r_data = 32'hBEEF_0001;
    #3;
    chk("pp_gnt", {62'd0, in_gnt}, 64'd1);
    chk("pp_route", in_r_data, {32'hBEEF_0001, 32'd0});
    step();
    idle();
    #3;
    chk("pp_count", {61'd0, outstanding_o}, 64'd2);
    step();
    out_r_valid = 1'b1;
    step(); step();
    idle();
    step();

    // Stray response with nothing outstanding.
    out_r_valid = 1'b1; out_r_data = 32'hDEAD_0000;
    #3;
    chk("stray_rvalid", {62'd0, in_r_valid}, 64'd0);
    step();
    idle();
    step(); step();
    #3;
    chk("stray_err_held", {63'd0, err_o}, 64'd1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #3;
    chk("stray_err_clear", {63'd0, err_o}, 64'd0);
    step();

    // Reset with three outstanding, then dual request favours port 0.
    in_req = 2'b01; out_gnt = 1'b1;
    step(); step(); step();
    idle();
    #3;
    chk("rst3_count", {61'd0, outstanding_o}, 64'd3);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #3;
    chk("rst3_cleared", {61'd0, outstanding_o}, 64'd0);
    step();
    in_req = 2'b11; out_gnt = 1'b1;
    #3;
    chk("rst3_first_gnt", {62'd0, in_gnt}, 64'd1);
    step();
    idle();
    out_r_valid = 1'b1;
    step();
    out_r_valid = 1'b1;
    #3;
    chk("late_resp_dropped", {62'd0, in_r_valid}, 64'd0);
    step();
    idle();
    #3;
    chk("late_resp_err", {63'd0, err_o}, 64'd1);
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_tcdm_mux.md
AES_TCDM_MUX -- requirements
Module: aes_tcdm_mux

Interface
REQ-001 SHALL have parameter MP, default 2: number of upstream HWPE-Mem slave ports (the accelerator's TCDM master ports).
REQ-002 SHALL have parameter DEPTH, default 4: maximum outstanding granted transactions (power of two, >=2).
REQ-003 SHALL use one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 in_req  in  MP  per-port request.
REQ-007 in_gnt  out  MP  per-port grant.
REQ-008 in_add  in  MPx32  per-port byte address.
REQ-009 in_wen  in  MP  per-port write-enable-n (1=read, 0=write).
REQ-010 in_be  in  MPx4  per-port byte enables.
REQ-011 in_data  in  MPx32  per-port write data.
REQ-012 in_r_data  out  MPx32  per-port read data.
REQ-013 in_r_valid  out  MP  per-port response valid.
REQ-014 out_req / out_add / out_wen / out_be / out_data  out  1/32/1/4/32  single memory-side request.
REQ-015 out_gnt  in  1  memory grant.
REQ-016 out_r_data / out_r_valid  in  32/1  memory response; exactly one per granted request (reads and writes), in order, >=1 cycle after grant.
REQ-017 outstanding_o  out  clog2(DEPTH+1)  current outstanding-transaction count.
REQ-018 err_o  out  1  sticky protocol-error flag.

Function
REQ-019 Arbitration SHALL be round-robin: starting from priority pointer ptr, the first port with in_req=1 (ascending index, wrapping MP-1->0) is selected (sel).
REQ-020 out_req SHALL equal (any in_req) AND (outstanding_o < DEPTH); combinational, zero latency.
REQ-021 out_add/out_wen/out_be/out_data SHALL be the selected port's fields combinationally; value don't-care when out_req=0.
REQ-022 in_gnt[sel] SHALL equal out_req AND out_gnt; all other in_gnt bits SHALL be 0.
REQ-023 On handshake (out_req & out_gnt), sel SHALL be pushed into an in-order ID FIFO of DEPTH entries and ptr SHALL become (sel+1) mod MP.
REQ-024 Without a handshake, ptr SHALL hold.
REQ-025 When outstanding_o == DEPTH (full), out_req SHALL be 0 and no in_gnt asserted, even if a response pops in that same cycle (no same-cycle refill).
REQ-026 On out_r_valid with FIFO non-empty: in_r_valid[head] = 1 and in_r_data[head] = out_r_data in the same cycle; other in_r_valid bits 0; head entry popped.
REQ-027 in_r_data of non-addressed ports SHALL be 0.
REQ-028 Simultaneous push and pop SHALL leave outstanding_o unchanged; pointers advance independently with wrap at DEPTH.
REQ-029 out_r_valid with FIFO empty SHALL be dropped (no in_r_valid), set err_o=1, and leave count unchanged.
REQ-030 err_o SHALL remain 1 until reset.
REQ-031 A held in_req that is not selected SHALL keep its request fields stable; the block does not buffer request data.

Reset
REQ-032 On rst_i=1 at a clock edge: ptr=0, FIFO read/write pointers=0, outstanding_o=0, err_o=0.
REQ-033 Reset mid-operation SHALL discard all outstanding entries; responses arriving after reset with empty FIFO SHALL set err_o per REQ-029.
REQ-034 While rst_i=1, outputs SHALL follow combinational rules with count=0 (in_gnt may assert if out_gnt=1); the bench holds in_req=0 during reset.

Verification
REQ-035 Both ports request continuously, out_gnt=1, response 1 cycle later -> grants alternate 0,1,0,1; each in_r_valid returns to the issuing port with its data.
REQ-036 out_gnt=1, responses withheld, port 0 requesting -> exactly 4 grants; outstanding_o=4; out_req=0; after one out_r_valid, out_req returns next cycle.
REQ-037 Port 1 reads 0x100 (data 0xA5A5A5A5), then port 0 writes 0x104; memory responds in order -> in_r_valid[1] with 0xA5A5A5A5, then in_r_valid[0]; outstanding_o back to 0.
REQ-038 Same cycle: handshake on port 0 and response for earlier port 1 request at count=2 -> count stays 2; response routed to port 1.
REQ-039 out_r_valid pulse with count=0 -> no in_r_valid; err_o=1, held until rst_i pulse clears it to 0.
REQ-040 Reset asserted with 3 outstanding -> outstanding_o=0, ptr=0; next dual request grants port 0 first.
